spi_master: RTL
===============

Name: spi_master

Overview:
- SPI master that drives the spi_clk/din inputs of the shift-register test slave and captures its dout.
- Mode 0: SCK idles low; MOSI changes on the falling edge; the slave shifts in on the rising edge; MISO is sampled on the rising edge.
- Sits between the MIDI router control logic (parallel word interface) and the serial SPI pins.
- One N-bit full-duplex transfer per start request, MSB first.

Parameters:
- N, 8, transfer word width in bits; N >= 2.
- CLK_DIV, 2, clk cycles per SCK half-period; CLK_DIV >= 1. SCK period = 2*CLK_DIV clk cycles.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  transfer request, sampled on posedge clk; acted on only when busy=0.
- tx_data  input  N  word to transmit; captured on the accepted start cycle.
- busy  output  1  high from the cycle after start is accepted through the done cycle.
- done  output  1  single-cycle pulse; rx_data is valid from this cycle.
- rx_data  output  N  last received word; holds until the next done.
- spi_clk  output  1  SCK to the slave.
- mosi  output  1  serial data out (slave din).
- miso  input  1  serial data in (slave dout).

Behaviour:
- Reset (async, immediate):
  - state=IDLE; spi_clk=0; mosi=0; busy=0; done=0; rx_data=0.
  - Internal counters and shift registers are cleared.
- States: IDLE, LOW, HIGH, DONE.
- IDLE:
  - spi_clk=0, busy=0.
  - On start=1: load tx shift register <= tx_data; mosi <= tx_data[N-1]; bit_cnt <= 0; div_cnt <= 0; busy <= 1; go to LOW.
- LOW:
  - div_cnt increments each clk.
  - When div_cnt == CLK_DIV-1: spi_clk <= 1; rx shift <= {rx shift[N-2:0], miso}; div_cnt <= 0; go to HIGH.
- HIGH:
  - div_cnt increments each clk.
  - When div_cnt == CLK_DIV-1: spi_clk <= 0; div_cnt <= 0.
    - If bit_cnt == N-1: go to DONE.
    - Else: bit_cnt++; shift tx register left; mosi <= next bit; go to LOW.
- DONE (one cycle):
  - rx_data <= rx shift; done=1; busy stays 1.
  - Next cycle: state IDLE, busy=0, done=0, mosi=0.
- Latency and counts:
  - Start accepted in cycle 0; rising SCK edges at cycles k*2*CLK_DIV + CLK_DIV, for k = 0..N-1.
  - done high in cycle 2*N*CLK_DIV + 1.
  - Exactly N rising and N falling SCK edges per transfer.
- Counter widths:
  - div_cnt is $clog2(CLK_DIV+1) bits; bit_cnt is $clog2(N) bits.
  - No wrap beyond the terminal values.
- start while busy=1 (including the DONE cycle): ignored, not queued. Earliest back-to-back start is the cycle after done.
- tx_data changes after acceptance: no effect on the current transfer.
- Reset mid-transfer: outputs return to reset values immediately. No done pulse; rx_data=0.
- Loopback through the shift-register slave returns the previously sent word. The slave loads dout on the falling edge, and the master samples on the rising edge.

Optional Feature:
- Macro: SPI_MASTER_CS_EN
- Defined:
  - Adds output port cs_n (1 bit), reset value 1.
  - cs_n <= 0 on the start-accept cycle, so it falls CLK_DIV cycles before the first rising SCK.
  - cs_n <= 1 in the DONE cycle.
  - Reset mid-transfer forces cs_n=1.
- Undefined: no cs_n port; all other behaviour identical.

Test Plan:
- Reset values: assert reset for 3 cycles, then release -> spi_clk=0, mosi=0, busy=0, done=0, rx_data=0x00 (N=8, CLK_DIV=2).
- Tied input and timing: miso tied 1, start with tx_data=0xA5 -> mosi sequence 1,0,1,0,0,1,0,1 across 8 SCK periods of 4 clk each; done in cycle 33; rx_data=0xFF; busy low in cycle 34.
- Loopback: slave shift register instantiated with N=8; send 0xA5, then 0x3C starting the cycle after done -> second rx_data=0xA5; a third transfer of 0x00 returns 0x3C.
- Start while busy: start pulses every cycle during a transfer of 0x81 -> exactly one done pulse; spi_clk shows exactly 8 rising edges; following transfer not started until a new start after busy=0.
- Reset mid-transfer: assert reset at cycle 10 of a transfer -> spi_clk=0 and busy=0 in the same cycle, no done pulse; a new start of 0x5A then completes normally.
- With SPI_MASTER_CS_EN, CLK_DIV=3: cs_n falls at start acceptance, first SCK rise 3 cycles later; cs_n=1 in the done cycle; reset mid-transfer -> cs_n=1 immediately.

Source files
------------

// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - parallel word and SPI pin bundle for spi_master; cs_n present when SPI_MASTER_CS_EN is defined
interface spi_master_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] tx_data;
  logic         busy;
  logic         done;
  logic [N-1:0] rx_data;
  logic         spi_clk;
  logic         mosi;
  logic         miso;
`ifdef SPI_MASTER_CS_EN
  logic         cs_n;
`endif

`ifdef SPI_MASTER_CS_EN
  modport master (
    input  start, tx_data, miso,
    output busy, done, rx_data, spi_clk, mosi, cs_n
  );
  modport slave (
    output start, tx_data, miso,
    input  busy, done, rx_data, spi_clk, mosi, cs_n
  );
`else
  modport master (
    input  start, tx_data, miso,
    output busy, done, rx_data, spi_clk, mosi
  );
  modport slave (
    output start, tx_data, miso,
    input  busy, done, rx_data, spi_clk, mosi
  );
`endif
endinterface

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 master, N-bit full-duplex MSB-first transfers; optional cs_n via SPI_MASTER_CS_EN
module spi_master #(
  parameter int N       = 8,
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  spi_master_if.master bus
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(N);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic [N-1:0]  tx_shift;
  logic [N-1:0]  rx_shift;

  // Transfer sequencer: IDLE waits for start, LOW/HIGH time each SCK half-period,
  // DONE publishes the received word. Acceptance is gated by state, so a start
  // in the cycle right after the done pulse begins the next transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      tx_shift     <= '0;
      rx_shift     <= '0;
      bus.spi_clk  <= 1'b0;
      bus.mosi     <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.rx_data  <= '0;
`ifdef SPI_MASTER_CS_EN
      bus.cs_n     <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus.spi_clk <= 1'b0;
          bus.done    <= 1'b0;
          if (bus.start) begin
            tx_shift <= bus.tx_data;
            bus.mosi <= bus.tx_data[N-1];
            bit_cnt  <= '0;
            div_cnt  <= '0;
            bus.busy <= 1'b1;
`ifdef SPI_MASTER_CS_EN
            bus.cs_n <= 1'b0;
`endif
            state    <= LOW;
          end else begin
            bus.busy <= 1'b0;
            bus.mosi <= 1'b0;
          end
        end
        LOW: begin
          if (div_cnt == DIV_LAST) begin
            // rising SCK: slave shifts in mosi, we capture miso
            bus.spi_clk <= 1'b1;
            rx_shift    <= {rx_shift[N-2:0], bus.miso};
            div_cnt     <= '0;
            state       <= HIGH;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        HIGH: begin
          if (div_cnt == DIV_LAST) begin
            // falling SCK: present the next bit unless this was the last one
            bus.spi_clk <= 1'b0;
            div_cnt     <= '0;
            if (bit_cnt == BIT_LAST) begin
              state <= DONE;
            end else begin
              bit_cnt  <= bit_cnt + BW'(1);
              tx_shift <= {tx_shift[N-2:0], 1'b0};
              bus.mosi <= tx_shift[N-2];
              state    <= LOW;
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        DONE: begin
          bus.rx_data <= rx_shift;
          bus.done    <= 1'b1;
`ifdef SPI_MASTER_CS_EN
          bus.cs_n    <= 1'b1;
`endif
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
